// File: rtl/cci_mpf_shim_pkg.sv
// Shared types and constants for the MPF c0 read shim.
package cci_mpf_shim_pkg;

  localparam int unsigned TX_MDATA_W = 16;
  localparam int unsigned CL_ADDR_W  = 42;
  localparam int unsigned CL_DATA_W  = 512;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DRAINING = 2'd1,
    ST_DRAINED  = 2'd2
  } drain_state_e;

  // One c0 read request as issued toward MPF.
  typedef struct packed {
    logic [CL_ADDR_W-1:0]  addr;
    logic [TX_MDATA_W-1:0] mdata;
  } c0_rd_req_t;

endpackage

// File: rtl/cci_mpf_rr_arb.sv
// Round-robin arbiter: priority starts one past the last granted index.
module cci_mpf_rr_arb #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] request,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    grant   = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = PW'((32'(ptr_q) + k) % N);
      if (!found && request[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        win_idx    = idx;
      end
    end
  end

  // Pointer only moves when the grant is actually consumed.
  always_comb begin
    ptr_d = ptr_q;
    if (advance && found) begin
      ptr_d = (32'(win_idx) == N - 1) ? '0 : PW'(32'(win_idx) + 1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/cci_mpf_c0_rd_arb.sv
// Arbitrates N_REQ read requesters onto the MPF c0 channel, caps in-flight
// reads, routes responses back by mdata id, and supports drain/quiesce.
module cci_mpf_c0_rd_arb
  import cci_mpf_shim_pkg::*;
#(
  parameter  int unsigned N_REQ           = 4,
  parameter  int unsigned MAX_OUTSTANDING = 256,
  parameter  int unsigned MDATA_W         = 12,
  localparam int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [N_REQ-1:0]                   req_valid,
  output logic [N_REQ-1:0]                   req_ready,
  input  logic [N_REQ-1:0][CL_ADDR_W-1:0]    req_addr,
  input  logic [N_REQ-1:0][MDATA_W-1:0]      req_mdata,
  output logic                               tx_valid,
  output logic [CL_ADDR_W-1:0]               tx_addr,
  output logic [TX_MDATA_W-1:0]              tx_mdata,
  input  logic                               tx_alm_full,
  input  logic                               rx_rd_valid,
  input  logic [TX_MDATA_W-1:0]              rx_mdata,
  input  logic [CL_DATA_W-1:0]               rx_data,
  output logic [N_REQ-1:0]                   rsp_valid,
  output logic [MDATA_W-1:0]                 rsp_mdata,
  output logic [CL_DATA_W-1:0]               rsp_data,
  input  logic                               drain_req,
  output logic                               drained,
  output logic [CNT_W-1:0]                   outstanding
);

  localparam int unsigned ID_W = TX_MDATA_W - MDATA_W;

  drain_state_e           state_q;
  logic                   drained_q;
  logic [N_REQ-1:0]       grant;
  logic                   can_issue_c;
  logic                   xfer_c;
  c0_rd_req_t             tx_q;
  c0_rd_req_t             tx_d;
  logic                   tx_valid_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic [ID_W-1:0]        rsp_id;
  logic [N_REQ-1:0]       rsp_valid_q;
  logic [N_REQ-1:0]       rsp_valid_d;
  logic [MDATA_W-1:0]     rsp_mdata_q;
  logic [CL_DATA_W-1:0]   rsp_data_q;

  cci_mpf_rr_arb #(
    .N (N_REQ)
  ) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .request (req_valid),
    .advance (can_issue_c),
    .grant   (grant)
  );

  // A registered issue counts against the cap before it reaches the counter.
  always_comb begin
    can_issue_c = reset_n && (state_q == ST_RUN) && !tx_alm_full &&
                  ((32'(cnt_q) + 32'(tx_valid_q)) < MAX_OUTSTANDING);
    req_ready   = can_issue_c ? grant : '0;
    xfer_c      = |(req_valid & req_ready);
  end

  always_comb begin
    tx_d = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (req_ready[i]) begin
        tx_d.addr  = req_addr[i];
        tx_d.mdata = {ID_W'(i), req_mdata[i]};
      end
    end
  end

  // Saturating in-flight counter; simultaneous issue and return cancel.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({tx_valid_q, rx_rd_valid})
      2'b10: if (32'(cnt_q) < MAX_OUTSTANDING) cnt_d = cnt_q + CNT_W'(1);
      2'b01: if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Responses with an id beyond N_REQ produce no strobe.
  always_comb begin
    rsp_id      = rx_mdata[TX_MDATA_W-1:MDATA_W];
    rsp_valid_d = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      rsp_valid_d[i] = rx_rd_valid && (32'(rsp_id) == i);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_valid_q  <= 1'b0;
      tx_q        <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_mdata_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      tx_valid_q  <= xfer_c;
      tx_q        <= tx_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      if (rx_rd_valid) begin
        rsp_mdata_q <= rx_mdata[MDATA_W-1:0];
        rsp_data_q  <= rx_data;
      end
    end
  end

  // Drain FSM; DRAINED is entered once the counter is about to hit zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_RUN;
      drained_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (drain_req) state_q <= ST_DRAINING;
        end
        ST_DRAINING: begin
          if ((cnt_d == '0) && !tx_valid_q) begin
            state_q   <= ST_DRAINED;
            drained_q <= 1'b1;
          end
        end
        ST_DRAINED: begin
          if (!drain_req) begin
            state_q   <= ST_RUN;
            drained_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_RUN;
          drained_q <= 1'b0;
        end
      endcase
    end
  end

  assign tx_valid    = tx_valid_q;
  assign tx_addr     = tx_q.addr;
  assign tx_mdata    = tx_q.mdata;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_mdata   = rsp_mdata_q;
  assign rsp_data    = rsp_data_q;
  assign drained     = drained_q;
  assign outstanding = cnt_q;

endmodule

// File: doc/cci_mpf_c0_rd_arb.md
CCI_MPF_C0_RD_ARB -- requirements
Module: cci_mpf_c0_rd_arb

Interface
REQ-001 Parameter N_REQ, default 4: number of read requesters, legal range 2..8.
REQ-002 Parameter MAX_OUTSTANDING, default 256: global cap on in-flight c0 reads, legal range 1..1024.
REQ-003 Parameter MDATA_W, default 12: width of the requester-supplied mdata field.
REQ-004 Port clk, input, 1: single clock for all logic.
REQ-005 Port reset_n, input, 1: reset, asynchronous and active-low.
REQ-006 Port req_valid, input, N_REQ: per-requester read request valid.
REQ-007 Port req_ready, output, N_REQ: per-requester accept; a request transfers when valid and ready are both high.
REQ-008 Port req_addr, input, N_REQ x 42: cache-line address per requester.
REQ-009 Port req_mdata, input, N_REQ x MDATA_W: requester tag, returned unchanged with the response.
REQ-010 Port tx_valid, output, 1: c0 read request valid toward the MPF c0Tx channel.
REQ-011 Port tx_addr, output, 42: issued address.
REQ-012 Port tx_mdata, output, 16: {requester id zero-extended to 16-MDATA_W bits, req_mdata}.
REQ-013 Port tx_alm_full, input, 1: c0TxAlmFull from MPF.
REQ-014 Port rx_rd_valid, input, 1: c0Rx read-response valid (MMIO traffic excluded upstream).
REQ-015 Port rx_mdata, input, 16: response mdata.
REQ-016 Port rx_data, input, 512: response data.
REQ-017 Port rsp_valid, output, N_REQ: one-hot response strobe to the owning requester.
REQ-018 Port rsp_mdata, output, MDATA_W; rsp_data, output, 512: shared response payload.
REQ-019 Port drain_req, input, 1: request to quiesce; drained, output, 1: quiesced.
REQ-020 Port outstanding, output, clog2(MAX_OUTSTANDING+1): current in-flight count.

Function
REQ-021 Grant is round-robin among asserted req_valid, starting at the index after the last granted requester; at most one req_ready is high per cycle.
REQ-022 req_ready[i] is combinational: high only when i wins arbitration, tx_alm_full=0, state=RUN, and outstanding plus an issue already registered this cycle is below MAX_OUTSTANDING.
REQ-023 An accepted request appears on tx_valid/tx_addr/tx_mdata exactly one cycle later, registered; tx_valid is low in every other cycle.
REQ-024 tx_alm_full asserted blocks all grants in the same cycle; a request already registered still issues.
REQ-025 The round-robin pointer advances only on an actual transfer.
REQ-026 The outstanding counter increments on tx_valid and decrements on rx_rd_valid; both in the same cycle leave it unchanged; it never wraps.
REQ-027 A response is forwarded one cycle after rx_rd_valid, registered: rsp_valid[rx_mdata[15:MDATA_W]] high, rsp_mdata = rx_mdata[MDATA_W-1:0], rsp_data = rx_data.
REQ-028 A response whose id is >= N_REQ is dropped (no rsp_valid) but still decrements outstanding.
REQ-029 FSM states: RUN, DRAINING, DRAINED.
REQ-030 FSM transitions: RUN->DRAINING on drain_req=1; DRAINING->DRAINED when outstanding=0 and no issue is pending; DRAINED->RUN on drain_req=0.
REQ-031 drained is high only in DRAINED; grants are suppressed in DRAINING and DRAINED; responses are always forwarded.

Reset
REQ-032 While reset_n=0: req_ready, tx_valid, rsp_valid, and drained are 0; outstanding is 0; the pointer is at requester 0; the state is RUN.
REQ-033 Asserting reset mid-operation discards in-flight accounting; the first grant after release goes to the lowest-indexed valid requester.

Structure
REQ-034 The state enum and the tx_mdata id-packing width constant belong in the shared package cci_mpf_shim_pkg.
REQ-035 The round-robin arbiter is a sub-module, cci_mpf_rr_arb (parameter N, inputs request/advance, output one-hot grant).

Verification
REQ-036 All 4 requesters valid continuously, tx_alm_full=0: grants follow 0,1,2,3,0; each tx_mdata[15:12] equals the requester id; tx_valid lags the grant by 1 cycle.
REQ-037 MAX_OUTSTANDING=2, no responses: after 2 issues req_ready stays 0; one rx_rd_valid brings outstanding to 1 and the next grant occurs the cycle after.
REQ-038 tx_alm_full=1 for 5 cycles with req_valid=4'b0010: no new tx_valid during the window except a request already registered; a grant resumes in the cycle tx_alm_full falls.
REQ-039 rx_mdata=16'h2ABC with rx_rd_valid: one cycle later rsp_valid=4'b0100 and rsp_mdata=12'hABC; rx_mdata=16'h5000 (N_REQ=4): no rsp_valid and outstanding decrements.
REQ-040 3 reads outstanding, drain_req=1: no grants follow; drained=1 one cycle after the third response; drain_req=0 returns the state to RUN and grants resume.
REQ-041 Same-cycle tx_valid and rx_rd_valid with outstanding=7: outstanding stays 7; reset_n pulsed low mid-traffic: all outputs are 0 immediately (asynchronous).
